// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: slot-state encoding and the canonical NOP used
// to fill an empty fetch/decode interface.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } slot_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the IF/ID register: a valid flag plus PC/instruction
// payload, with synchronous load and clear. Only the valid flag is reset.
module pipe_slot #(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [INST_W-1:0] d_inst,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [INST_W-1:0] inst
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload is never reset; consumers qualify it with valid.
    always_ff @(posedge clk) begin
        if (load) begin
            pc   <= d_pc;
            inst <= d_inst;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with ready/valid handshake. Defining IF_ID_SKID_EN
// adds a skid slot (registered in_ready, up to two entries held).
module if_id_skid_reg
    import pipe_pkg::*;
#(
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [1:0]        occupancy
);

    localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

    slot_state_e state_q, state_d;

    logic              push, pop;
    logic              main_load, main_clear;
    logic              main_valid;
    logic [PC_W-1:0]   main_pc, main_d_pc;
    logic [INST_W-1:0] main_inst, main_d_inst;

`ifdef IF_ID_SKID_EN
    logic              skid_load, skid_clear, from_skid;
    logic              skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              in_ready_q;
`endif

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (state_q != ST_EMPTY);

    always_comb begin
        state_d    = state_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
`ifdef IF_ID_SKID_EN
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        from_skid  = 1'b0;
`endif
        if (flush) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
`ifdef IF_ID_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d   = ST_HALF;
                        main_load = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        state_d    = ST_EMPTY;
                        main_clear = 1'b1;
                    end else if (push) begin
`ifdef IF_ID_SKID_EN
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
`endif
                    end
                end
`ifdef IF_ID_SKID_EN
                ST_FULL: begin
                    // in_ready is low here, so a pop simply promotes the skid entry.
                    if (pop) begin
                        state_d    = ST_HALF;
                        main_load  = 1'b1;
                        from_skid  = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d    = ST_EMPTY;
                    main_clear = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef IF_ID_SKID_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    assign in_ready    = in_ready_q;
    assign main_d_pc   = from_skid ? skid_pc   : in_pc;
    assign main_d_inst = from_skid ? skid_inst : in_inst;
    assign occupancy   = {1'b0, main_valid} + {1'b0, skid_valid};

    pipe_slot #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_skid_slot (
        .clk    (clk),
        .reset  (reset),
        .clear  (skid_clear),
        .load   (skid_load),
        .d_pc   (in_pc),
        .d_inst (in_inst),
        .valid  (skid_valid),
        .pc     (skid_pc),
        .inst   (skid_inst)
    );
`else
    assign in_ready    = !out_valid | out_ready;
    assign main_d_pc   = in_pc;
    assign main_d_inst = in_inst;
    assign occupancy   = {1'b0, main_valid};
`endif

    pipe_slot #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_main_slot (
        .clk    (clk),
        .reset  (reset),
        .clear  (main_clear),
        .load   (main_load),
        .d_pc   (main_d_pc),
        .d_inst (main_d_inst),
        .valid  (main_valid),
        .pc     (main_pc),
        .inst   (main_inst)
    );

    // Empty interface presents PC 0 and a NOP rather than stale payload.
    assign out_pc   = main_valid ? main_pc   : '0;
    assign out_inst = main_valid ? main_inst : NOP_W;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed self-checking bench for if_id_skid_reg; follows IF_ID_SKID_EN
// to select the two-entry or single-entry expectations.
module tb_if_id_skid_reg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic [1:0]        occupancy;

    int n_cmp = 0;
    int n_err = 0;

    if_id_skid_reg #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_pc"},    out_pc,         64'd0);
        check_val({tag, "_inst"},  64'(out_inst),  64'h13);
        check_val({tag, "_occ"},   64'(occupancy), 64'd0);
        check_val({tag, "_rdy"},   64'(in_ready),  64'd1);
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    // Leaves the block holding as many entries as it can take with out_ready low.
    task automatic fill();
        out_ready = 1'b0;
        drive(1'b1, 64'h1000, 32'h0050_0093);
        tick();
`ifdef IF_ID_SKID_EN
        drive(1'b1, 64'h1004, 32'h0060_0113);
        tick();
`endif
        drive(1'b0, 64'h0, 32'h0);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 64'h0, 32'h0);
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;

        // Single transfer, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 64'h1000, 32'h0050_0093);
        tick();
        drive(1'b0, 64'hdead, 32'hffff_ffff);
        #1;
        check_val("lat_valid", 64'(out_valid), 64'd1);
        check_val("lat_pc",    out_pc,         64'h1000);
        check_val("lat_inst",  64'(out_inst),  64'h0050_0093);
        check_val("lat_occ",   64'(occupancy), 64'd1);
        tick();
        check_idle("drain");

`ifdef IF_ID_SKID_EN
        // Two entries held, then drained in order
        fill();
        check_val("full_occ", 64'(occupancy), 64'd2);
        check_val("full_rdy", 64'(in_ready),  64'd0);
        check_val("full_pc",  out_pc,         64'h1000);
        tick();
        check_val("hold_pc",   out_pc,        64'h1000);
        check_val("hold_inst", 64'(out_inst), 64'h0050_0093);
        out_ready = 1'b1;
        #1;
        check_val("pop0_pc", out_pc, 64'h1000);
        tick();
        check_val("pop1_pc",   out_pc,         64'h1004);
        check_val("pop1_inst", 64'(out_inst),  64'h0060_0113);
        check_val("pop1_occ",  64'(occupancy), 64'd1);
        check_val("pop1_rdy",  64'(in_ready),  64'd1);
        tick();
        check_idle("pop2");
`else
        // Single-entry: in_ready follows out_ready combinationally
        out_ready = 1'b0;
        drive(1'b1, 64'h1000, 32'h0050_0093);
        tick();
        drive(1'b1, 64'h1004, 32'h0060_0113);
        #1;
        check_val("stall_rdy", 64'(in_ready), 64'd0);
        check_val("stall_pc",  out_pc,        64'h1000);
        tick();
        check_val("hold_pc",   out_pc,         64'h1000);
        check_val("hold_inst", 64'(out_inst),  64'h0050_0093);
        check_val("hold_occ",  64'(occupancy), 64'd1);
        out_ready = 1'b1;
        #1;
        check_val("go_rdy", 64'(in_ready), 64'd1);
        tick();
        check_val("next_pc",   out_pc,         64'h1004);
        check_val("next_inst", 64'(out_inst),  64'h0060_0113);
        check_val("next_occ",  64'(occupancy), 64'd1);
        drive(1'b0, 64'h0, 32'h0);
        tick();
        check_idle("drain2");
`endif

        // Flush dominates a concurrent push
        fill();
        flush = 1'b1;
        drive(1'b1, 64'h3000, 32'h0070_0193);
        tick();
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0);
        #1;
        check_idle("flush");

        // Simultaneous push and pop in HALF
        out_ready = 1'b0;
        drive(1'b1, 64'h1000, 32'h0050_0093);
        tick();
        out_ready = 1'b1;
        drive(1'b1, 64'h2000, 32'h0080_0213);
        tick();
        drive(1'b0, 64'h0, 32'h0);
        #1;
        check_val("pp_occ",  64'(occupancy), 64'd1);
        check_val("pp_pc",   out_pc,         64'h2000);
        check_val("pp_inst", 64'(out_inst),  64'h0080_0213);
        tick();
        check_idle("pp_drain");

        // Reset beats flush, push and stalled pop
        fill();
        reset = 1'b1;
        flush = 1'b1;
        drive(1'b1, 64'h4000, 32'h0090_0293);
        tick();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, 64'h0, 32'h0);
        #1;
        check_idle("rst_full");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/if_id_skid_reg.md
IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 SHALL have parameter PC_W, default 64, program-counter width in bits.
REQ-002 SHALL have parameter INST_W, default 32, instruction width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  fetch presents a valid PC/instruction pair.
REQ-006 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-007 SHALL have port in_pc  input  PC_W  fetched PC.
REQ-008 SHALL have port in_inst  input  INST_W  fetched instruction.
REQ-009 SHALL have port flush  input  1  discard all held entries (branch/jump redirect).
REQ-010 SHALL have port out_valid  output  1  decode-side pair is valid.
REQ-011 SHALL have port out_ready  input  1  decode consumes the pair this cycle.
REQ-012 SHALL have port out_pc  output  PC_W  PC to decode.
REQ-013 SHALL have port out_inst  output  INST_W  instruction to decode.
REQ-014 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-015 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-016 SHALL implement states EMPTY (0 entries), HALF (main slot full), FULL (main + skid slot full).
REQ-017 SHALL transition: EMPTY+push->HALF; HALF+push&!pop->FULL; HALF+pop&!push->EMPTY; HALF+push&pop->HALF (main <= input); FULL+pop->HALF (main <= skid); all other cases hold.
REQ-018 SHALL give 1-cycle latency: a pair pushed at edge N drives out_* with out_valid=1 after edge N when state was EMPTY.
REQ-019 SHALL preserve strict FIFO order; no pair is duplicated or dropped except by flush/reset.
REQ-020 SHALL drive in_ready as a registered signal: 1 in EMPTY/HALF, 0 in FULL.
REQ-021 SHALL drive out_valid = (state != EMPTY), always from the main slot.
REQ-022 SHALL hold out_pc/out_inst stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive out_pc=0 and out_inst=NOP_INST (32'h0000_0013, zero-extended to INST_W) whenever out_valid=0.
REQ-024 SHALL, on flush=1, go to EMPTY at the next edge; a push or pop in the same cycle is discarded and flush dominates.
REQ-025 SHALL report occupancy = 0/1/2 for EMPTY/HALF/FULL.
REQ-026 SHALL ignore in_pc/in_inst when push=0.

Reset
REQ-027 SHALL, with reset=1 at an edge, set state EMPTY, out_valid=0, out_pc=0, out_inst=NOP_INST, occupancy=0, in_ready=1 after that edge.
REQ-028 SHALL give reset priority over flush, push and pop; reset mid-transfer discards both slots.

Configuration
REQ-029 SHALL, with IF_ID_SKID_EN defined, implement the two-entry skid behaviour above.
REQ-030 SHALL, without IF_ID_SKID_EN, omit the skid slot: states EMPTY/HALF only, in_ready = !out_valid | out_ready (combinational), occupancy never exceeds 1; all other requirements unchanged.

Structure
REQ-031 SHALL take NOP_INST and the state enumeration typedef from shared package pipe_pkg.
REQ-032 SHALL build each storage slot from sub-module pipe_slot (valid + PC + instruction register with load and clear), instantiated twice (once without IF_ID_SKID_EN).

Verification
REQ-033 SHALL check: reset, then in_valid=1, in_pc=0x1000, in_inst=0x00500093, out_ready=1 -> next cycle out_valid=1, out_pc=0x1000, out_inst=0x00500093.
REQ-034 SHALL check: out_ready=0, push 0x1000 then 0x1004 -> occupancy=2, in_ready=0, out_pc held at 0x1000; out_ready=1 -> 0x1000 then 0x1004 in order.
REQ-035 SHALL check: FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, out_inst=0x00000013, out_pc=0, occupancy=0, in_ready=1.
REQ-036 SHALL check: HALF with push 0x2000 and pop same cycle -> occupancy stays 1, out_pc=0x2000.
REQ-037 SHALL check: reset=1 and flush=1 while FULL -> all outputs at reset values after the edge.
REQ-038 SHALL check, without IF_ID_SKID_EN: out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
